out_read_arbiter: RTL and testbench
===================================

// Module: out_read_arbiter
// PURPOSE
//  Sequences frame-buffer readout for the active output path (VGA or UART).
//  Serves the matching requester with row-length READ_EN bursts, keeps row and column counters, and swaps the ping-pong buffer half.
//  Changes output path only at frame boundaries.
//  Sits between the frame buffer and the VGA/UART readers; drives the buffer read controls through the output mux.
// PARAMETERS
//  ROW_LEN   640    words per row burst (READ_EN high cycles per grant)
//  ROWS      480    rows per frame
//  CNT_W     10     width of CNT_ROW/CNT_COL; 2^CNT_W >= max(ROW_LEN,ROWS)
//  GAP       2      idle cycles after each burst before next grant (>=1)
//  TIMEOUT   65535  stall limit in cycles; used only with OUT_ARB_TIMEOUT_EN
// PORTS
//  CLK_25       in   1      system clock; all logic on rising edge
//  RESET_N      in   1      synchronous, active-low reset
//  MODE_SEL     in   1      requested path: 1=VGA, 0=UART
//  FRAME_READY  in   1      1-cycle pulse: capture finished writing back half
//  VGA_REQ      in   1      level: VGA reader wants next row
//  UART_REQ     in   1      level: UART reader wants next row
//  VGA_GNT      out  1      VGA burst in progress
//  UART_GNT     out  1      UART burst in progress
//  READ_EN      out  1      buffer read strobe
//  CNT_ROW      out  CNT_W  current row, 0..ROWS-1
//  CNT_COL      out  CNT_W  word index in burst, 0..ROW_LEN-1
//  ROW_DONE     out  1      1-cycle pulse after last word of a row
//  FRAME_DONE   out  1      1-cycle pulse after last word of last row
//  BUF_CHANGE   out  1      read-half select level; toggles on swap
//  ACTIVE_VGA   out  1      latched path: 1=VGA, 0=UART
//  ABORT        out  1      1-cycle pulse on stall abort (0 without macro)
// BEHAVIOUR
//  Reset (RESET_N=0 at an edge):
//   - All outputs go to 0; FSM goes to IDLE; pending-swap flag clears.
//   - Applies mid-burst too: READ_EN and GNT drop at that edge.
//   - ACTIVE_VGA re-latches MODE_SEL on the first IDLE cycle after reset.
//  FSM: IDLE -> BURST -> GAP -> IDLE.
//  IDLE:
//   - If CNT_ROW==0, ACTIVE_VGA<=MODE_SEL. This is the only point where the path changes.
//   - The active path's REQ=1 sampled -> BURST next edge. The inactive path's REQ is ignored.
//  BURST:
//   - GNT(active) and READ_EN are 1 for exactly ROW_LEN cycles.
//   - CNT_COL counts 0..ROW_LEN-1 while READ_EN=1. First READ_EN is 1 cycle after REQ is sampled.
//   - Dropping REQ mid-burst does not abort; the burst completes.
//  After the last word:
//   - GNT, READ_EN and CNT_COL go to 0. ROW_DONE pulses for 1 cycle.
//   - CNT_ROW increments. At ROWS-1 it wraps to 0, and FRAME_DONE pulses in the same cycle as ROW_DONE.
//   - Then GAP cycles in GAP, then IDLE. REQ held through GAP is served right after.
//  Buffer swap:
//   - FRAME_READY sets the pending flag.
//   - On the FRAME_DONE cycle, if (pending | FRAME_READY): BUF_CHANGE toggles and pending clears.
//   - FRAME_READY in the same cycle as FRAME_DONE is consumed, not lost.
//   - Repeated FRAME_READY pulses with no FRAME_DONE between them give one swap.
//  MODE_SEL changes mid-frame take effect only after FRAME_DONE.
//  VGA_GNT and UART_GNT are never 1 together.
// CONFIGURATION
//  OUT_ARB_TIMEOUT_EN defined:
//   - A counter runs while in IDLE with CNT_ROW!=0 and the active REQ=0.
//   - When it reaches TIMEOUT: CNT_ROW<=0, ABORT pulses for 1 cycle, no FRAME_DONE, no swap.
//   - The path may then re-latch. This recovers from a stalled UART host.
//  Undefined: no counter; ABORT is tied 0; a stalled frame waits forever.
// TESTING (ROW_LEN=4, ROWS=3, GAP=2, TIMEOUT=20)
//  1. Reset, MODE_SEL=1, hold VGA_REQ=1
//     -> READ_EN high 4 cycles, CNT_COL 0,1,2,3; ROW_DONE; CNT_ROW=1.
//     -> 2 gap cycles, next burst; after row 2, CNT_ROW=0 and FRAME_DONE pulse.
//  2. UART_REQ=1 with ACTIVE_VGA=1 -> UART_GNT stays 0, READ_EN stays 0.
//  3. FRAME_READY pulse during row 1 -> BUF_CHANGE 0->1 on the FRAME_DONE cycle.
//     No FRAME_READY in the next frame -> no toggle.
//  4. MODE_SEL 1->0 during row 1 -> ACTIVE_VGA stays 1 until FRAME_DONE, then 0.
//     The next grant goes to UART_REQ only.
//  5. RESET_N=0 at COL=2 mid-burst -> next edge: READ_EN=0, CNT_ROW=0, BUF_CHANGE=0.
//  6. [OUT_ARB_TIMEOUT_EN] UART active, CNT_ROW=1, UART_REQ=0 for 20 cycles
//     -> ABORT pulse, CNT_ROW=0, no FRAME_DONE.

Source files
------------

// File: rtl/out_read_arbiter_if.sv
// Bus between the output read arbiter and its VGA/UART readers.
// master is the arbiter side; slave is the reader/capture side.
interface out_read_arbiter_if #(
    parameter int CNT_W = 10
);
    // Handshake: REQ is a level that the reader holds while it wants a row.
    // The arbiter answers with GNT and READ_EN high together for one whole row
    // burst. GNT is not withdrawn when REQ drops, and the readers cannot stall a burst.
    logic             MODE_SEL;
    logic             FRAME_READY;
    logic             VGA_REQ;
    logic             UART_REQ;
    logic             VGA_GNT;
    logic             UART_GNT;
    logic             READ_EN;
    logic [CNT_W-1:0] CNT_ROW;
    logic [CNT_W-1:0] CNT_COL;
    logic             ROW_DONE;
    logic             FRAME_DONE;
    logic             BUF_CHANGE;
    logic             ACTIVE_VGA;
    logic             ABORT;

    modport master (
        input  MODE_SEL, FRAME_READY, VGA_REQ, UART_REQ,
        output VGA_GNT, UART_GNT, READ_EN, CNT_ROW, CNT_COL,
               ROW_DONE, FRAME_DONE, BUF_CHANGE, ACTIVE_VGA, ABORT
    );

    modport slave (
        output MODE_SEL, FRAME_READY, VGA_REQ, UART_REQ,
        input  VGA_GNT, UART_GNT, READ_EN, CNT_ROW, CNT_COL,
               ROW_DONE, FRAME_DONE, BUF_CHANGE, ACTIVE_VGA, ABORT
    );
endinterface

// File: rtl/out_read_arbiter.sv
// Frame-buffer readout sequencer: row bursts for the latched VGA/UART path plus ping-pong swap.
// Define OUT_ARB_TIMEOUT_EN to add the stalled-frame abort counter (ABORT is tied 0 otherwise).
module out_read_arbiter #(
    parameter int ROW_LEN = 640,
    parameter int ROWS    = 480,
    parameter int CNT_W   = 10,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 65535
) (
    input  logic                  CLK_25,
    input  logic                  RESET_N,
    out_read_arbiter_if.master    bus,
    output logic [1:0]            dbg_state_o
);

    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    if (GAP < 1) begin : g_bad_gap
        $error("GAP must be at least 1");
    end
    if (ROW_LEN < 1 || ROWS < 1 || (1 << CNT_W) < ROW_LEN || (1 << CNT_W) < ROWS) begin : g_bad_cnt
        $error("CNT_W too narrow for ROW_LEN/ROWS");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t             state_q;
    logic [GAP_W-1:0]   gap_q;
    logic [CNT_W-1:0]   row_q;
    logic [CNT_W-1:0]   col_q;
    logic               read_en_q;
    logic               vga_gnt_q;
    logic               uart_gnt_q;
    logic               row_done_q;
    logic               frame_done_q;
    logic               buf_q;
    logic               act_vga_q;
    logic               pending_q;

    logic               act_vga_d;
    logic               act_req_d;
    logic               last_word_d;
    logic               last_row_d;
    logic               swap_d;

    // The path only re-latches while sitting at the top of a frame, so the
    // request decision in IDLE uses the value that is about to be latched.
    always_comb begin
        act_vga_d   = (row_q == '0) ? bus.MODE_SEL : act_vga_q;
        act_req_d   = act_vga_d ? bus.VGA_REQ : bus.UART_REQ;
        last_word_d = (col_q == CNT_W'(ROW_LEN - 1));
        last_row_d  = (row_q == CNT_W'(ROWS - 1));
        swap_d      = pending_q | bus.FRAME_READY;
    end

`ifdef OUT_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] to_q;
    logic            abort_q;
`endif

    always_ff @(posedge CLK_25) begin
        if (!RESET_N) begin
            state_q      <= S_IDLE;
            gap_q        <= '0;
            row_q        <= '0;
            col_q        <= '0;
            read_en_q    <= 1'b0;
            vga_gnt_q    <= 1'b0;
            uart_gnt_q   <= 1'b0;
            row_done_q   <= 1'b0;
            frame_done_q <= 1'b0;
            buf_q        <= 1'b0;
            act_vga_q    <= 1'b0;
            pending_q    <= 1'b0;
`ifdef OUT_ARB_TIMEOUT_EN
            to_q         <= '0;
            abort_q      <= 1'b0;
`endif
        end else begin
            row_done_q   <= 1'b0;
            frame_done_q <= 1'b0;
            if (bus.FRAME_READY) begin
                pending_q <= 1'b1;
            end
`ifdef OUT_ARB_TIMEOUT_EN
            abort_q <= 1'b0;
            to_q    <= '0;
`endif
            case (state_q)
                S_IDLE: begin
                    act_vga_q <= act_vga_d;
                    if (act_req_d) begin
                        state_q    <= S_BURST;
                        read_en_q  <= 1'b1;
                        vga_gnt_q  <= act_vga_d;
                        uart_gnt_q <= ~act_vga_d;
                        col_q      <= '0;
                    end
`ifdef OUT_ARB_TIMEOUT_EN
                    // A reader that stops asking mid-frame would otherwise pin
                    // the path forever; give up on the frame after TIMEOUT cycles.
                    else if (row_q != '0) begin
                        if (to_q == TO_W'(TIMEOUT - 1)) begin
                            row_q   <= '0;
                            abort_q <= 1'b1;
                        end else begin
                            to_q <= to_q + TO_W'(1);
                        end
                    end
`endif
                end
                S_BURST: begin
                    if (last_word_d) begin
                        state_q    <= S_GAP;
                        gap_q      <= '0;
                        read_en_q  <= 1'b0;
                        vga_gnt_q  <= 1'b0;
                        uart_gnt_q <= 1'b0;
                        col_q      <= '0;
                        row_done_q <= 1'b1;
                        if (last_row_d) begin
                            row_q        <= '0;
                            frame_done_q <= 1'b1;
                            // A FRAME_READY arriving on this very edge is folded into the swap.
                            if (swap_d) begin
                                buf_q     <= ~buf_q;
                                pending_q <= 1'b0;
                            end
                        end else begin
                            row_q <= row_q + CNT_W'(1);
                        end
                    end else begin
                        col_q <= col_q + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (gap_q == GAP_W'(GAP - 1)) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.VGA_GNT    = vga_gnt_q;
    assign bus.UART_GNT   = uart_gnt_q;
    assign bus.READ_EN    = read_en_q;
    assign bus.CNT_ROW    = row_q;
    assign bus.CNT_COL    = col_q;
    assign bus.ROW_DONE   = row_done_q;
    assign bus.FRAME_DONE = frame_done_q;
    assign bus.BUF_CHANGE = buf_q;
    assign bus.ACTIVE_VGA = act_vga_q;
`ifdef OUT_ARB_TIMEOUT_EN
    assign bus.ABORT      = abort_q;
`else
    assign bus.ABORT      = 1'b0;
`endif
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_out_read_arbiter.sv
// Directed bench for out_read_arbiter with ROW_LEN=4, ROWS=3, GAP=2, TIMEOUT=20.
module tb_out_read_arbiter;
    localparam int ROW_LEN = 4;
    localparam int ROWS    = 3;
    localparam int CNT_W   = 10;
    localparam int GAP     = 2;
    localparam int TIMEOUT = 20;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [CNT_W-1:0] exp_q[$];
    bit both_gnt_seen = 0;
    bit abort_seen    = 0;

    out_read_arbiter_if #(.CNT_W(CNT_W)) bus ();

    out_read_arbiter #(
        .ROW_LEN(ROW_LEN), .ROWS(ROWS), .CNT_W(CNT_W), .GAP(GAP), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK_25      (clk),
        .RESET_N     (rst_n),
        .bus         (bus.master),
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #20 clk = ~clk;

    always @(negedge clk) begin
        if (bus.VGA_GNT && bus.UART_GNT) both_gnt_seen = 1;
        if (bus.ABORT) abort_seen = 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Waits for a burst, checks it word by word and the cycle after its last word.
    task automatic run_burst(input string tag, input bit exp_vga, input int exp_wait,
                             input int exp_row, input bit exp_fd, input bit exp_buf,
                             input int fr_col, input int mode_col, input bit new_mode);
        int w;
        logic [CNT_W-1:0] e;
        w = 0;
        step();
        while (!bus.READ_EN && w < 30) begin
            step();
            w++;
        end
        check({tag, "_wait"}, w, exp_wait);
        for (int c = 0; c < ROW_LEN; c++) exp_q.push_back(c[CNT_W-1:0]);
        for (int c = 0; c < ROW_LEN; c++) begin
            e = exp_q.pop_front();
            check({tag, "_rd"},   bus.READ_EN, 1);
            check({tag, "_vgnt"}, bus.VGA_GNT, exp_vga);
            check({tag, "_ugnt"}, bus.UART_GNT, !exp_vga);
            check({tag, "_col"},  bus.CNT_COL, e);
            bus.FRAME_READY = (c == fr_col);
            if (c == mode_col) bus.MODE_SEL = new_mode;
            step();
        end
        bus.FRAME_READY = 1'b0;
        check({tag, "_rd_off"}, bus.READ_EN, 0);
        check({tag, "_gnt_off"}, bus.VGA_GNT | bus.UART_GNT, 0);
        check({tag, "_rowdone"}, bus.ROW_DONE, 1);
        check({tag, "_framedone"}, bus.FRAME_DONE, exp_fd);
        check({tag, "_row"}, bus.CNT_ROW, exp_row);
        check({tag, "_col0"}, bus.CNT_COL, 0);
        check({tag, "_buf"}, bus.BUF_CHANGE, exp_buf);
    endtask

    initial begin
        int  w;
        bit  seen;
        rst_n           = 1'b0;
        bus.MODE_SEL    = 1'b1;
        bus.FRAME_READY = 1'b0;
        bus.VGA_REQ     = 1'b0;
        bus.UART_REQ    = 1'b0;
        step();
        step();
        check("rst_read_en", bus.READ_EN, 0);
        check("rst_gnt", {bus.VGA_GNT, bus.UART_GNT}, 0);
        check("rst_row", bus.CNT_ROW, 0);
        check("rst_col", bus.CNT_COL, 0);
        check("rst_pulses", {bus.ROW_DONE, bus.FRAME_DONE, bus.ABORT}, 0);
        check("rst_buf", bus.BUF_CHANGE, 0);
        check("rst_active", bus.ACTIVE_VGA, 0);
        check("rst_state", dbg_state, 0);

        // Frame A: VGA path, UART_REQ asserted but must be ignored, FRAME_READY in row 1
        rst_n        = 1'b1;
        bus.VGA_REQ  = 1'b1;
        bus.UART_REQ = 1'b1;
        run_burst("a_r0", 1, 0, 1, 0, 0, -1, -1, 1'b1);
        check("a_active", bus.ACTIVE_VGA, 1);
        run_burst("a_r1", 1, 2, 2, 0, 0, 1, -1, 1'b1);
        run_burst("a_r2", 1, 2, 0, 1, 1, -1, -1, 1'b1);

        // Frame B: inactive UART request alone gets nothing; MODE_SEL flips in row 1
        run_burst("b_r0", 1, 2, 1, 0, 1, -1, -1, 1'b1);
        bus.VGA_REQ = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.READ_EN || bus.UART_GNT) seen = 1;
        end
        check("b_uart_ignored", seen, 0);
        check("b_idle_state", dbg_state, 0);
        bus.VGA_REQ = 1'b1;
        run_burst("b_r1", 1, 0, 2, 0, 1, -1, 1, 1'b0);
        check("b_active_hold", bus.ACTIVE_VGA, 1);
        run_burst("b_r2", 1, 2, 0, 1, 1, -1, -1, 1'b0);
        check("b_active_fd", bus.ACTIVE_VGA, 1);

        // Frame C: path is now UART even though VGA_REQ stays high
        run_burst("c_r0", 0, 2, 1, 0, 1, -1, -1, 1'b0);
        check("c_active", bus.ACTIVE_VGA, 0);
        w = 0;
        step();
        while (!bus.READ_EN && w < 30) begin
            step();
            w++;
        end
        check("c_r1_wait", w, 2);
        step();
        step();
        check("c_r1_col2", bus.CNT_COL, 2);
        rst_n = 1'b0;
        step();
        check("c_rst_read_en", bus.READ_EN, 0);
        check("c_rst_gnt", bus.UART_GNT, 0);
        check("c_rst_row", bus.CNT_ROW, 0);
        check("c_rst_col", bus.CNT_COL, 0);
        check("c_rst_buf", bus.BUF_CHANGE, 0);
        check("c_rst_active", bus.ACTIVE_VGA, 0);
        bus.MODE_SEL = 1'b1;
        bus.UART_REQ = 1'b0;
        rst_n        = 1'b1;

        // Frame D: two FRAME_READY pulses make a single swap
        run_burst("d_r0", 1, 0, 1, 0, 0, 2, -1, 1'b1);
        check("d_active", bus.ACTIVE_VGA, 1);
        run_burst("d_r1", 1, 2, 2, 0, 0, 0, -1, 1'b1);
        run_burst("d_r2", 1, 2, 0, 1, 1, -1, -1, 1'b1);

        // Frame E: FRAME_READY only on the last word of the frame is still honoured
        run_burst("e_r0", 1, 2, 1, 0, 1, -1, -1, 1'b1);
        run_burst("e_r1", 1, 2, 2, 0, 1, -1, -1, 1'b1);
        run_burst("e_r2", 1, 2, 0, 1, 0, 3, -1, 1'b1);

`ifdef OUT_ARB_TIMEOUT_EN
        // Frame F: UART stalls after row 0 and the frame is abandoned
        bus.MODE_SEL = 1'b0;
        bus.VGA_REQ  = 1'b0;
        bus.UART_REQ = 1'b1;
        run_burst("f_r0", 0, 2, 1, 0, 0, -1, -1, 1'b0);
        bus.UART_REQ = 1'b0;
        w    = 0;
        seen = 0;
        while (!bus.ABORT && w < 60) begin
            step();
            w++;
            if (bus.FRAME_DONE) seen = 1;
        end
        check("f_abort", bus.ABORT, 1);
        check("f_abort_delay", w, GAP + TIMEOUT);
        check("f_no_framedone", seen, 0);
        check("f_row", bus.CNT_ROW, 0);
        check("f_buf", bus.BUF_CHANGE, 0);
        step();
        check("f_abort_pulse", bus.ABORT, 0);
`else
        step();
        check("abort_tied_low", abort_seen, 0);
`endif
        check("gnt_exclusive", both_gnt_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
